// File: rtl/fabric_pkg.sv
// Shared definitions for the fabric memory-side blocks.
//   clog2_safe           : ceil(log2(n)), never less than 1, for index/pointer widths
//   COMP_STORE_ARB_PARAM : error code reported when the store arbiter is
//                          elaborated with illegal parameters
package fabric_pkg;

   localparam int COMP_STORE_ARB_PARAM = 32'h0000_0301;

   function automatic int clog2_safe(input int n);
      return ($clog2(n) < 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/fabric_id_fifo.sv
// In-order index FIFO. It records small tags, such as requester indices, so
// that in-order completions can be routed back to their sources.
// A push while full and a pop while empty are ignored. A push and a pop in
// the same cycle are both honoured.
//   clk, rst_n  : clock, async active-low reset (clears storage, pointers, count)
//   push_i      : write push_data_i at the tail
//   push_data_i : tag to store
//   pop_i       : drop the head entry
//   head_o      : entry at the head (valid when !empty_o)
//   full_o      : count_o == DEPTH
//   empty_o     : count_o == 0
//   count_o     : current occupancy
module fabric_id_fifo
   import fabric_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int WIDTH = 2,
   localparam int CNT_W = clog2_safe(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   localparam int                PTR_W    = clog2_safe(DEPTH);
   localparam logic [PTR_W-1:0]  LAST     = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == FULL_CNT);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;

   // Pointers wrap explicitly so that DEPTH does not have to be a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_ok) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/fabric_store_arbiter.sv
// Shares one memory write port among NUM_PORTS store requesters.
// Arbitration is round-robin, and the priority pointer moves only on an
// issue. Each issued write records its port in an in-order ID FIFO. Each
// memory ack is returned as a done token to the port at the FIFO head.
//   clk, rst_n        : clock, async active-low reset
//   req_valid/ready   : per-port store handshake (ready == issued this cycle)
//   req_addr/data     : packed per-port address/data, port i at [i*W +: W]
//   mem_wr_*          : write request towards memory (zero-latency pass-through)
//   mem_ack_valid/rdy : in-order write completions from memory
//   done_valid/ready  : per-port completion tokens
//   outstanding       : writes in flight (ID FIFO occupancy)
//   err_spurious_ack  : sticky, set by an ack while nothing is in flight
module fabric_store_arbiter
   import fabric_pkg::*;
#(
   parameter int NUM_PORTS       = 4,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 8,
   localparam int ID_W  = clog2_safe(NUM_PORTS),
   localparam int CNT_W = clog2_safe(MAX_OUTSTANDING + 1)
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_PORTS-1:0]            req_valid,
   output logic [NUM_PORTS-1:0]            req_ready,
   input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
   output logic                            mem_wr_valid,
   input  logic                            mem_wr_ready,
   output logic [ADDR_WIDTH-1:0]           mem_wr_addr,
   output logic [DATA_WIDTH-1:0]           mem_wr_data,
   input  logic                            mem_ack_valid,
   output logic                            mem_ack_ready,
   output logic [NUM_PORTS-1:0]            done_valid,
   input  logic [NUM_PORTS-1:0]            done_ready,
   output logic [CNT_W-1:0]                outstanding,
   output logic                            err_spurious_ack
);

   if (NUM_PORTS < 2) begin : g_chk_ports
      $fatal(1, "error %0h: NUM_PORTS must be >= 2", COMP_STORE_ARB_PARAM);
   end
   if (MAX_OUTSTANDING < 1) begin : g_chk_outst
      $fatal(1, "error %0h: MAX_OUTSTANDING must be >= 1", COMP_STORE_ARB_PARAM);
   end
   if (ADDR_WIDTH < 1) begin : g_chk_addr
      $fatal(1, "error %0h: ADDR_WIDTH must be >= 1", COMP_STORE_ARB_PARAM);
   end

   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic            err_q, err_d;
   logic [ID_W-1:0] scan_idx;
   logic [ID_W-1:0] grant_idx;
   logic            grant_found;
   logic            can_issue, issue, retire;
   logic [ID_W-1:0] head;
   logic            fifo_full, fifo_empty, nonempty;

   // Round-robin scan that starts at rr_ptr_q. The grant depends only on
   // registered state and the current req_valid, so a stalled request keeps
   // the same grant while the requesters hold their valids.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_idx    = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         scan_idx = ID_W'((int'(rr_ptr_q) + i) % NUM_PORTS);
         if (!grant_found && req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // The full check uses the registered count. A retire in the same cycle
   // does not free a slot until the next cycle, which gives a one-cycle bubble.
   assign can_issue    = grant_found && !fifo_full;
   assign issue        = can_issue && mem_wr_ready;
   assign mem_wr_valid = can_issue;
   assign mem_wr_addr  = grant_found ? req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH] : '0;
   assign mem_wr_data  = grant_found ? req_data[grant_idx*DATA_WIDTH +: DATA_WIDTH] : '0;

   assign nonempty      = !fifo_empty;
   assign mem_ack_ready = nonempty ? done_ready[head] : 1'b1;
   assign retire        = mem_ack_valid && nonempty && done_ready[head];

   always_comb begin
      req_ready  = '0;
      done_valid = '0;
      if (issue) req_ready[grant_idx] = 1'b1;
      if (mem_ack_valid && nonempty) done_valid[head] = 1'b1;
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (issue) rr_ptr_d = (grant_idx == ID_W'(NUM_PORTS - 1)) ? '0 : grant_idx + ID_W'(1);
      // An ack with nothing in flight is consumed but flagged.
      err_d = err_q | (mem_ack_valid && !nonempty);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
         err_q    <= 1'b0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         err_q    <= err_d;
      end
   end

   assign err_spurious_ack = err_q;

   fabric_id_fifo #(
      .DEPTH (MAX_OUTSTANDING),
      .WIDTH (ID_W)
   ) u_id_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (issue),
      .push_data_i (grant_idx),
      .pop_i       (retire),
      .head_o      (head),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (outstanding)
   );

endmodule

// File: tb/tb_fabric_store_arbiter.sv
module tb_fabric_store_arbiter;

   localparam int NP = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   logic           clk;
   logic           rst_n;

   // main instance, MAX_OUTSTANDING = 8
   logic [NP-1:0]    req_valid, req_ready, done_valid, done_ready;
   logic [NP*AW-1:0] req_addr;
   logic [NP*DW-1:0] req_data;
   logic             mem_wr_valid, mem_wr_ready, mem_ack_valid, mem_ack_ready, err;
   logic [AW-1:0]    mem_wr_addr;
   logic [DW-1:0]    mem_wr_data;
   logic [3:0]       outstanding;

   // second instance, MAX_OUTSTANDING = 2, used for the full condition
   logic [NP-1:0]    f_req_valid, f_req_ready, f_done_valid, f_done_ready;
   logic             f_mem_wr_valid, f_mem_wr_ready, f_mem_ack_valid, f_mem_ack_ready, f_err;
   logic [AW-1:0]    f_mem_wr_addr;
   logic [DW-1:0]    f_mem_wr_data;
   logic [1:0]       f_outstanding;

   int errors = 0;
   int checks = 0;
   int sb[$];
   int exp_p;
   logic [NP-1:0] ev;

   fabric_store_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
      .mem_ack_valid(mem_ack_valid), .mem_ack_ready(mem_ack_ready),
      .done_valid(done_valid), .done_ready(done_ready),
      .outstanding(outstanding), .err_spurious_ack(err)
   );

   fabric_store_arbiter #(.NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(2)) dut_f (
      .clk(clk), .rst_n(rst_n),
      .req_valid(f_req_valid), .req_ready(f_req_ready), .req_addr(req_addr), .req_data(req_data),
      .mem_wr_valid(f_mem_wr_valid), .mem_wr_ready(f_mem_wr_ready),
      .mem_wr_addr(f_mem_wr_addr), .mem_wr_data(f_mem_wr_data),
      .mem_ack_valid(f_mem_ack_valid), .mem_ack_ready(f_mem_ack_ready),
      .done_valid(f_done_valid), .done_ready(f_done_ready),
      .outstanding(f_outstanding), .err_spurious_ack(f_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   function automatic logic [AW-1:0] addr_of(input int p);
      return 32'h1000_0000 + 32'(p) * 32'h100;
   endfunction

   function automatic logic [DW-1:0] data_of(input int p);
      return 32'hD000_0000 + 32'(p);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Each expected port on the scoreboard must come back as a done pulse,
   // with the acks returned in order.
   task automatic drain_main(input int n);
      mem_ack_valid = 1'b1;
      done_ready    = '1;
      for (int j = 0; j < n; j++) begin
         #1;
         exp_p = (sb.size() != 0) ? sb.pop_front() : 0;
         ev = NP'(1 << exp_p);
         checks++;
         if (done_valid !== ev) begin errors++; $display("FAIL drain_done: got %b expected %b", done_valid, ev); end
         checks++;
         if (mem_ack_ready !== 1'b1) begin errors++; $display("FAIL drain_ack_ready: got %b expected 1", mem_ack_ready); end
         tick();
      end
      mem_ack_valid = 1'b0;
      #1;
      checks++;
      if (outstanding !== 4'd0) begin errors++; $display("FAIL drain_outstanding: got %0d expected 0", outstanding); end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL rst_wr_valid: got %b expected 0", mem_wr_valid); end
      checks++;
      if (req_ready !== 4'b0) begin errors++; $display("FAIL rst_req_ready: got %b expected 0", req_ready); end
      checks++;
      if (done_valid !== 4'b0) begin errors++; $display("FAIL rst_done_valid: got %b expected 0", done_valid); end
      checks++;
      if (outstanding !== 4'd0) begin errors++; $display("FAIL rst_outstanding: got %0d expected 0", outstanding); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", err); end
      checks++;
      if (mem_ack_ready !== 1'b1) begin errors++; $display("FAIL rst_ack_ready: got %b expected 1", mem_ack_ready); end
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_round_robin();
      req_valid    = 4'hF;
      mem_wr_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         ev = NP'(1 << (k % NP));
         checks++;
         if (mem_wr_valid !== 1'b1) begin errors++; $display("FAIL rr_valid k=%0d: got %b expected 1", k, mem_wr_valid); end
         checks++;
         if (req_ready !== ev) begin errors++; $display("FAIL rr_grant k=%0d: got %b expected %b", k, req_ready, ev); end
         checks++;
         if (mem_wr_addr !== addr_of(k % NP)) begin errors++; $display("FAIL rr_addr k=%0d: got %h expected %h", k, mem_wr_addr, addr_of(k % NP)); end
         checks++;
         if (mem_wr_data !== data_of(k % NP)) begin errors++; $display("FAIL rr_data k=%0d: got %h expected %h", k, mem_wr_data, data_of(k % NP)); end
         sb.push_back(k % NP);
         tick();
      end
      req_valid    = '0;
      mem_wr_ready = 1'b0;
      #1;
      checks++;
      if (outstanding !== 4'd5) begin errors++; $display("FAIL rr_outstanding: got %0d expected 5", outstanding); end
      drain_main(5);
   endtask

   // priority pointer is 1 here (last grant was port 0)
   task automatic test_back_pressure();
      req_valid    = 4'b1010;
      mem_wr_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (mem_wr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid k=%0d: got %b expected 1", k, mem_wr_valid); end
         checks++;
         if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_ready k=%0d: got %b expected 0000", k, req_ready); end
         checks++;
         if (mem_wr_addr !== addr_of(1)) begin errors++; $display("FAIL bp_addr k=%0d: got %h expected %h", k, mem_wr_addr, addr_of(1)); end
         tick();
      end
      mem_wr_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_fire1: got %b expected 0010", req_ready); end
      sb.push_back(1);
      tick();
      checks++;
      if (req_ready !== 4'b1000) begin errors++; $display("FAIL bp_fire3: got %b expected 1000", req_ready); end
      checks++;
      if (mem_wr_addr !== addr_of(3)) begin errors++; $display("FAIL bp_addr3: got %h expected %h", mem_wr_addr, addr_of(3)); end
      sb.push_back(3);
      tick();
      req_valid    = '0;
      mem_wr_ready = 1'b0;
      drain_main(2);
   endtask

   task automatic test_ordering();
      int seq [3] = '{2, 0, 2};
      mem_wr_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         req_valid = NP'(1 << seq[k]);
         #1;
         checks++;
         if (req_ready !== NP'(1 << seq[k])) begin errors++; $display("FAIL ord_issue k=%0d: got %b expected %b", k, req_ready, NP'(1 << seq[k])); end
         sb.push_back(seq[k]);
         tick();
      end
      req_valid    = '0;
      mem_wr_ready = 1'b0;
      mem_ack_valid = 1'b1;
      done_ready    = '1;
      for (int j = 0; j < 3; j++) begin
         #1;
         checks++;
         if (outstanding !== 4'(3 - j)) begin errors++; $display("FAIL ord_count j=%0d: got %0d expected %0d", j, outstanding, 3 - j); end
         exp_p = (sb.size() != 0) ? sb.pop_front() : 0;
         ev = NP'(1 << exp_p);
         checks++;
         if (done_valid !== ev) begin errors++; $display("FAIL ord_done j=%0d: got %b expected %b", j, done_valid, ev); end
         tick();
      end
      mem_ack_valid = 1'b0;
      #1;
      checks++;
      if (outstanding !== 4'd0) begin errors++; $display("FAIL ord_final: got %0d expected 0", outstanding); end
   endtask

   // issue and retire in the same cycle leaves the occupancy unchanged
   task automatic test_back_to_back();
      req_valid    = 4'b0010;
      mem_wr_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_issue: got %b expected 0010", req_ready); end
      sb.push_back(1);
      tick();
      mem_ack_valid = 1'b1;
      done_ready    = '1;
      #1;
      exp_p = (sb.size() != 0) ? sb.pop_front() : 0;
      ev = NP'(1 << exp_p);
      checks++;
      if (done_valid !== ev) begin errors++; $display("FAIL b2b_done: got %b expected %b", done_valid, ev); end
      checks++;
      if (req_ready !== 4'b0010) begin errors++; $display("FAIL b2b_issue2: got %b expected 0010", req_ready); end
      sb.push_back(1);
      tick();
      req_valid     = '0;
      mem_wr_ready  = 1'b0;
      mem_ack_valid = 1'b0;
      #1;
      checks++;
      if (outstanding !== 4'd1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", outstanding); end
      drain_main(1);
   endtask

   task automatic test_done_bp_spurious();
      req_valid    = 4'b0001;
      mem_wr_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0001) begin errors++; $display("FAIL dbp_issue: got %b expected 0001", req_ready); end
      sb.push_back(0);
      tick();
      req_valid     = '0;
      mem_wr_ready  = 1'b0;
      mem_ack_valid = 1'b1;
      done_ready    = 4'b1110;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (done_valid !== 4'b0001) begin errors++; $display("FAIL dbp_done_valid k=%0d: got %b expected 0001", k, done_valid); end
         checks++;
         if (mem_ack_ready !== 1'b0) begin errors++; $display("FAIL dbp_ack_ready k=%0d: got %b expected 0", k, mem_ack_ready); end
         tick();
         checks++;
         if (outstanding !== 4'd1) begin errors++; $display("FAIL dbp_count k=%0d: got %0d expected 1", k, outstanding); end
      end
      drain_main(1);
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL spur_pre_err: got %b expected 0", err); end
      mem_ack_valid = 1'b1;
      #1;
      checks++;
      if (mem_ack_ready !== 1'b1) begin errors++; $display("FAIL spur_ack_ready: got %b expected 1", mem_ack_ready); end
      checks++;
      if (done_valid !== 4'b0) begin errors++; $display("FAIL spur_done: got %b expected 0000", done_valid); end
      tick();
      mem_ack_valid = 1'b0;
      #1;
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL spur_err_set: got %b expected 1", err); end
      repeat (3) tick();
      checks++;
      if (err !== 1'b1) begin errors++; $display("FAIL spur_err_sticky: got %b expected 1", err); end
   endtask

   task automatic test_full();
      f_req_valid    = 4'b0001;
      f_mem_wr_ready = 1'b1;
      f_done_ready   = '1;
      for (int k = 0; k < 2; k++) begin
         #1;
         checks++;
         if (f_req_ready !== 4'b0001) begin errors++; $display("FAIL full_fill k=%0d: got %b expected 0001", k, f_req_ready); end
         sb.push_back(0);
         tick();
      end
      checks++;
      if (f_outstanding !== 2'd2) begin errors++; $display("FAIL full_count: got %0d expected 2", f_outstanding); end
      checks++;
      if (f_mem_wr_valid !== 1'b0) begin errors++; $display("FAIL full_blocked: got %b expected 0", f_mem_wr_valid); end
      tick();
      checks++;
      if (f_req_ready !== 4'b0) begin errors++; $display("FAIL full_held: got %b expected 0000", f_req_ready); end
      f_mem_ack_valid = 1'b1;
      #1;
      exp_p = (sb.size() != 0) ? sb.pop_front() : 0;
      ev = NP'(1 << exp_p);
      checks++;
      if (f_done_valid !== ev) begin errors++; $display("FAIL full_ack_done: got %b expected %b", f_done_valid, ev); end
      checks++;
      if (f_mem_wr_valid !== 1'b0) begin errors++; $display("FAIL full_bubble: got %b expected 0", f_mem_wr_valid); end
      tick();
      f_mem_ack_valid = 1'b0;
      #1;
      checks++;
      if (f_outstanding !== 2'd1) begin errors++; $display("FAIL full_after_ack: got %0d expected 1", f_outstanding); end
      checks++;
      if (f_req_ready !== 4'b0001) begin errors++; $display("FAIL full_reissue: got %b expected 0001", f_req_ready); end
      sb.push_back(0);
      tick();
      f_req_valid    = '0;
      f_mem_wr_ready = 1'b0;
      f_mem_ack_valid = 1'b1;
      for (int j = 0; j < 2; j++) begin
         #1;
         exp_p = (sb.size() != 0) ? sb.pop_front() : 0;
         ev = NP'(1 << exp_p);
         checks++;
         if (f_done_valid !== ev) begin errors++; $display("FAIL full_drain j=%0d: got %b expected %b", j, f_done_valid, ev); end
         tick();
      end
      f_mem_ack_valid = 1'b0;
      #1;
      checks++;
      if (f_outstanding !== 2'd0) begin errors++; $display("FAIL full_empty: got %0d expected 0", f_outstanding); end
   endtask

   task automatic test_reset_mid_traffic();
      req_valid    = 4'b1011;
      mem_wr_ready = 1'b1;
      repeat (3) tick();
      req_valid    = '0;
      mem_wr_ready = 1'b0;
      #1;
      checks++;
      if (outstanding !== 4'd3) begin errors++; $display("FAIL mid_pre_count: got %0d expected 3", outstanding); end
      rst_n         = 1'b0;
      mem_ack_valid = 1'b1;
      #1;
      checks++;
      if (outstanding !== 4'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", outstanding); end
      checks++;
      if (mem_wr_valid !== 1'b0) begin errors++; $display("FAIL mid_wr_valid: got %b expected 0", mem_wr_valid); end
      checks++;
      if (done_valid !== 4'b0) begin errors++; $display("FAIL mid_done: got %b expected 0000", done_valid); end
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL mid_err: got %b expected 0", err); end
      checks++;
      if (mem_ack_ready !== 1'b1) begin errors++; $display("FAIL mid_ack_ready: got %b expected 1", mem_ack_ready); end
      mem_ack_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      req_valid = 4'hF;
      #1;
      checks++;
      if (mem_wr_addr !== addr_of(0)) begin errors++; $display("FAIL mid_rr_reset: got %h expected %h", mem_wr_addr, addr_of(0)); end
      req_valid    = 4'b0100;
      mem_wr_ready = 1'b1;
      #1;
      checks++;
      if (req_ready !== 4'b0100) begin errors++; $display("FAIL mid_first_grant: got %b expected 0100", req_ready); end
      checks++;
      if (mem_wr_addr !== addr_of(2)) begin errors++; $display("FAIL mid_first_addr: got %h expected %h", mem_wr_addr, addr_of(2)); end
      tick();
      req_valid    = '0;
      mem_wr_ready = 1'b0;
      #1;
      checks++;
      if (outstanding !== 4'd1) begin errors++; $display("FAIL mid_post_count: got %0d expected 1", outstanding); end
   endtask

   initial begin
      rst_n           = 1'b0;
      req_valid       = '0;
      mem_wr_ready    = 1'b0;
      mem_ack_valid   = 1'b0;
      done_ready      = '0;
      f_req_valid     = '0;
      f_mem_wr_ready  = 1'b0;
      f_mem_ack_valid = 1'b0;
      f_done_ready    = '0;
      for (int p = 0; p < NP; p++) begin
         req_addr[p*AW +: AW] = addr_of(p);
         req_data[p*DW +: DW] = data_of(p);
      end
      repeat (2) @(posedge clk);

      test_reset();
      test_round_robin();
      test_back_pressure();
      test_ordering();
      test_back_to_back();
      test_done_bp_spurious();
      test_full();
      test_reset_mid_traffic();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
